// File: rtl/arm_pkg.sv
// Shared fetch-stage types and constants for the pipelined ARM core.
// Contents: fetch FSM state enum, queue entry layout at default core widths,
// and the sequential PC step.
package arm_pkg;

  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned ENTRY_AW = 32;
  localparam int unsigned ENTRY_IW = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } fetch_state_t;

  // Prefetch queue entry: instruction word plus the PC+8 value decode expects.
  typedef struct packed {
    logic [ENTRY_IW-1:0] inst;
    logic [ENTRY_AW-1:0] pc8;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO of fetch entries with synchronous clear.
// Ports:
//   clock, rst_n  clock / asynchronous active-low reset
//   push, din     write one entry (ignored when full)
//   pop           retire the head entry (ignored when empty)
//   clear         drop all entries; wins over push and pop
//   dout          head entry (registered storage, no bypass)
//   count, empty  occupancy and empty flag
module fetch_fifo
  import arm_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  input  logic                   clear,
  output entry_t                 dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage needs no reset: validity is tracked by count.
  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the PC, issues requests to a 1-cycle-latency
// instruction memory and buffers responses in a DEPTH-entry prefetch queue.
// WB/EX redirects flush the queue; an epoch tag drops stale responses.
// Optional feature macro: FETCH_STATS_EN adds stat_fetched, stat_redirects,
// stat_stall_cycles counters (32b, wrapping).
// Ports:
//   clock, rst_n                 clock / asynchronous active-low reset
//   redir_wb, redir_wb_pc        WB redirect and target (higher priority)
//   redir_ex, redir_ex_pc        EX taken branch and target
//   imem_req, imem_addr          fetch request and address (= PC)
//   imem_rvalid, imem_rdata      memory response, one cycle after request
//   dec_ready                    decode accepts head entry
//   dec_valid, dec_inst, dec_pc8 head entry presented to decode
module fetch_queue_unit
  import arm_pkg::*;
#(
  parameter int unsigned    AW        = 32,
  parameter int unsigned    IW        = 32,
  parameter int unsigned    DEPTH     = 4,
  parameter logic [AW-1:0]  RESET_VEC = '0
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          redir_wb,
  input  logic [AW-1:0] redir_wb_pc,
  input  logic          redir_ex,
  input  logic [AW-1:0] redir_ex_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  input  logic          dec_ready,
  output logic          dec_valid,
  output logic [IW-1:0] dec_inst,
  output logic [AW-1:0] dec_pc8
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]   stat_fetched,
  output logic [31:0]   stat_redirects,
  output logic [31:0]   stat_stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc8;
  } entry_t;

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] req_pc_q;
  logic          epoch_q;
  logic          tag_q;
  logic          inflight_q;

  logic          redir;
  logic [AW-1:0] redir_pc;
  logic          pop;
  logic          push;
  logic [OW-1:0] occ;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  entry_t        head;
  entry_t        push_entry;

  // WB redirect belongs to the older instruction, so it wins over EX.
  assign redir    = redir_wb | redir_ex;
  assign redir_pc = redir_wb ? redir_wb_pc : redir_ex_pc;

  assign dec_valid = !fifo_empty;
  assign dec_inst  = head.inst;
  assign dec_pc8   = head.pc8;
  assign imem_addr = pc_q;

  // A pop coinciding with a redirect is discarded along with the queue.
  assign pop = dec_valid && dec_ready && !redir;
  assign occ = OW'(fifo_count) + OW'(inflight_q);

  // Responses tagged with an old epoch belong to a flushed path.
  assign push = imem_rvalid && inflight_q && (tag_q == epoch_q) && !redir;
  assign push_entry = '{inst: imem_rdata, pc8: req_pc_q + AW'(2 * PC_STEP)};

  // Next state and fetch request.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        imem_req = (occ < (OW'(DEPTH) + OW'(pop)));
        if ((occ == OW'(DEPTH)) && !pop) state_d = FULL;
      end
      FULL: if (pop) state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (redir) begin
      state_d  = RUN;
      imem_req = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // PC, epoch and in-flight tracking.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      req_pc_q   <= '0;
      epoch_q    <= 1'b0;
      tag_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_req;
      if (redir) begin
        pc_q    <= redir_pc;
        epoch_q <= ~epoch_q;
      end else if (imem_req) begin
        pc_q     <= pc_q + AW'(PC_STEP);
        req_pc_q <= pc_q;
        tag_q    <= epoch_q;
      end
    end
  end

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .clear (redir),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

`ifdef FETCH_STATS_EN
  // Event counters: pushes, redirects, and cycles decode starves while running.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched      <= '0;
      stat_redirects    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      stat_fetched   <= stat_fetched + 32'(push);
      stat_redirects <= stat_redirects + 32'(redir);
      if (((state_q == RUN) || (state_q == FULL)) && !dec_valid)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios plus random
// ready/redirect traffic checked against an in-order instruction-stream model.
module tb_fetch_queue_unit;

  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          redir_wb;
  logic [AW-1:0] redir_wb_pc;
  logic          redir_ex;
  logic [AW-1:0] redir_ex_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid = 1'b0;
  logic [IW-1:0] imem_rdata  = '0;
  logic          dec_ready;
  logic          dec_valid;
  logic [IW-1:0] dec_inst;
  logic [AW-1:0] dec_pc8;
`ifdef FETCH_STATS_EN
  logic [31:0]   stat_fetched;
  logic [31:0]   stat_redirects;
  logic [31:0]   stat_stall_cycles;
`endif

  always #5 clock = ~clock;

  fetch_queue_unit #(
    .AW        (AW),
    .IW        (IW),
    .DEPTH     (DEPTH),
    .RESET_VEC (32'h0)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .redir_wb    (redir_wb),
    .redir_wb_pc (redir_wb_pc),
    .redir_ex    (redir_ex),
    .redir_ex_pc (redir_ex_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_ready   (dec_ready),
    .dec_valid   (dec_valid),
    .dec_inst    (dec_inst),
    .dec_pc8     (dec_pc8)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched      (stat_fetched),
    .stat_redirects    (stat_redirects),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  // Instruction memory: answers one cycle later with the address as data.
  always @(posedge clock) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= imem_addr;
  end

  int            n_checks;
  int            n_fail;
  logic [AW-1:0] exp_req;
  logic [AW-1:0] exp_pop;
  int            model_occ;
  bit            expect_empty;
  logic          obs_req;
  logic          obs_valid;
  logic [AW-1:0] obs_addr;
  logic [AW-1:0] obs_pc8;
  bit            saw_300;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_req      = 32'h0;
    exp_pop      = 32'h0;
    model_occ    = 0;
    expect_empty = 1'b0;
  endtask

  // One cycle: drive at negedge, sample 1ns later, update the stream model.
  // Model: addresses are requested, and delivered to decode, as an unbroken
  // +4 sequence from the last reset/redirect target; at most DEPTH entries
  // may be requested but not yet consumed.
  task automatic step(input bit rdy, input bit wb, input logic [AW-1:0] wbpc,
                      input bit ex, input logic [AW-1:0] expc);
    bit            redir;
    logic [AW-1:0] tgt;
    logic [AW-1:0] pc8e;
    dec_ready   = rdy;
    redir_wb    = wb;
    redir_wb_pc = wbpc;
    redir_ex    = ex;
    redir_ex_pc = expc;
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = dec_valid;
    obs_pc8   = dec_pc8;
    redir = wb | ex;
    tgt   = wb ? wbpc : expc;
    if (expect_empty) check("flush_empty", dec_valid, 0);
    if (dec_valid) begin
      pc8e = exp_pop + 32'd8;
      check("dec_inst", dec_inst, exp_pop);
      check("dec_pc8", dec_pc8, pc8e);
      if (rdy && !redir) begin
        exp_pop = exp_pop + 32'd4;
        model_occ--;
      end
    end
    if (imem_req) begin
      check("req_addr", imem_addr, exp_req);
      check("no_req_on_redir", redir, 0);
      exp_req = exp_req + 32'd4;
      model_occ++;
      check("occ_bound", model_occ <= DEPTH, 1);
    end
    if (redir) begin
      exp_req   = tgt;
      exp_pop   = tgt;
      model_occ = 0;
    end
    expect_empty = redir;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    dec_ready   = 1'b0;
    redir_wb    = 1'b0;
    redir_wb_pc = '0;
    redir_ex    = 1'b0;
    redir_ex_pc = '0;
    saw_300     = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", dec_valid, 0);
    check("rst_addr", imem_addr, 32'h0);
    @(negedge clock);
    rst_n = 1'b1;

    // 1: boot, 2-cycle latency, one instruction per cycle
    for (int i = 0; i < 12; i++) begin
      step(1, 0, '0, 0, '0);
      if (i == 0) check("boot_noreq", obs_req, 0);
      if (i == 1) check("first_req", obs_req, 1);
      if (i < 3)  check("lat_valid_low", obs_valid, 0);
      if (i == 3) check("first_pc8", obs_pc8, 32'h8);
      if (i >= 3) check("stream_valid", obs_valid, 1);
    end

    // 2: decode stall fills queue, then drains in order
    for (int i = 0; i < 10; i++) step(0, 0, '0, 0, '0);
    check("stall_occ", model_occ, DEPTH);
    check("stall_noreq", obs_req, 0);
    check("stall_valid", obs_valid, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, '0, 0, '0);
      check("drain_valid", obs_valid, 1);
    end

    // 3: EX redirect with a response in flight
    step(1, 0, '0, 1, 32'h100);
    step(1, 0, '0, 0, '0);
    check("ex_req", obs_req, 1);
    check("ex_addr", obs_addr, 32'h100);
    step(1, 0, '0, 0, '0);
    check("ex_gap", obs_valid, 0);
    step(1, 0, '0, 0, '0);
    check("ex_valid", obs_valid, 1);
    check("ex_pc8", obs_pc8, 32'h108);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, '0);

    // 4: simultaneous redirects, WB wins
    step(1, 1, 32'h200, 1, 32'h300);
    step(1, 0, '0, 0, '0);
    check("wb_req", obs_req, 1);
    check("wb_addr", obs_addr, 32'h200);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, '0, 0, '0);
      if (obs_req && (obs_addr == 32'h300)) saw_300 = 1'b1;
    end
    check("ex_target_unused", saw_300, 0);

    // 5: PC wrap
    step(1, 0, '0, 1, 32'hFFFF_FFFC);
    step(1, 0, '0, 0, '0);
    step(1, 0, '0, 0, '0);
    check("wrap_req", obs_req, 1);
    check("wrap_addr", obs_addr, 32'h0);
    step(1, 0, '0, 0, '0);
    check("wrap_valid", obs_valid, 1);
    check("wrap_pc8", obs_pc8, 32'h4);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, '0);

    // Redirect while decode is stalled
    for (int i = 0; i < 6; i++) step(0, 0, '0, 0, '0);
    step(0, 0, '0, 1, 32'h400);
    step(0, 0, '0, 0, '0);
    check("stall_redir_empty", obs_valid, 0);

    // Random ready/redirect traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [AW-1:0] t;
      r = $urandom_range(0, 99);
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = {28'hFFFF_FFF, t[3:0]};
      step($urandom_range(0, 9) < 7, r < 3, t, (r >= 3) && (r < 7), ~t);
    end

    // 6: async reset mid-burst, stale response after release ignored
    for (int i = 0; i < 5; i++) step(1, 0, '0, 0, '0);
    rst_n = 1'b0;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_valid", dec_valid, 0);
    check("arst_addr", imem_addr, 32'h0);
`ifdef FETCH_STATS_EN
    check("arst_stat_fetched", stat_fetched, 0);
    check("arst_stat_redirects", stat_redirects, 0);
    check("arst_stat_stall", stat_stall_cycles, 0);
`endif
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, '0, 0, '0);
      if (i == 0) check("rb_noreq", obs_req, 0);
      if (i < 3)  check("rb_valid_low", obs_valid, 0);
      if (i == 3) check("rb_pc8", obs_pc8, 32'h8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
